// File: rtl/vc_mem_port_arbiter.sv
// Shares one memory request port among p_num_reqs requesters and steers in-order
// responses back through a tag FIFO. Define VC_MEM_PORT_ARBITER_RR_EN for round-robin
// arbitration; otherwise the lowest-index requester always wins.

// Memory message layout: {type(1), addr, len($clog2(data bytes)), data} for requests,
// {type(1), len, data} for responses.
`ifndef VC_MEM_REQ_MSG_SZ
`define VC_MEM_REQ_MSG_SZ(a_, d_) (1 + (a_) + $clog2((d_) / 8) + (d_))
`endif
`ifndef VC_MEM_RESP_MSG_SZ
`define VC_MEM_RESP_MSG_SZ(d_) (1 + $clog2((d_) / 8) + (d_))
`endif

module vc_mem_port_arbiter #(
  parameter  int p_num_reqs       = 2,
  parameter  int p_addr_sz        = 8,
  parameter  int p_data_sz        = 32,
  parameter  int p_max_inflight   = 4,
  localparam int c_memreq_msg_sz  = `VC_MEM_REQ_MSG_SZ(p_addr_sz, p_data_sz),
  localparam int c_memresp_msg_sz = `VC_MEM_RESP_MSG_SZ(p_data_sz),
  localparam int c_id_sz          = $clog2(p_num_reqs)
) (
  input  logic                                   clk,
  input  logic                                   reset_n,

  input  logic [p_num_reqs*c_memreq_msg_sz-1:0]  req_msg,
  input  logic [p_num_reqs-1:0]                  req_val,
  output logic [p_num_reqs-1:0]                  req_rdy,

  output logic [c_memreq_msg_sz-1:0]             memreq_msg,
  output logic                                   memreq_val,
  input  logic                                   memreq_rdy,

  input  logic [c_memresp_msg_sz-1:0]            memresp_msg,
  input  logic                                   memresp_val,
  output logic                                   memresp_rdy,

  output logic [p_num_reqs*c_memresp_msg_sz-1:0] resp_msg,
  output logic [p_num_reqs-1:0]                  resp_val,
  input  logic [p_num_reqs-1:0]                  resp_rdy
);

  localparam int c_ptr_sz = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
  localparam int c_cnt_sz = $clog2(p_max_inflight) + 1;

  typedef logic [c_id_sz-1:0]  id_t;
  typedef logic [c_ptr_sz-1:0] ptr_t;
  typedef logic [c_cnt_sz-1:0] cnt_t;

  // Tag FIFO state
  id_t  tags [p_max_inflight];
  ptr_t head;
  ptr_t tail;
  cnt_t count;
  logic empty;
  logic full;

  // Arbitration and handshake signals
  id_t  scan_start;
  id_t  grant_id;
  logic grant_any;
  id_t  head_id;
  logic can_issue;
  logic issue_fire;
  logic resp_fire;

  assign empty   = (count == '0);
  assign full    = (count == cnt_t'(p_max_inflight));
  assign head_id = tags[head];

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p_max_inflight == 1) ? '0 : p + ptr_t'(1);
  endfunction

`ifdef VC_MEM_PORT_ARBITER_RR_EN
  id_t prio;
  assign scan_start = prio;
`else
  assign scan_start = '0;
`endif

  // First valid requester at or after scan_start, wrapping modulo p_num_reqs.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first so no latch is inferred.
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 0; k < p_num_reqs; k++) begin
      idx = int'(scan_start) + k;
      if (idx >= p_num_reqs) idx = idx - p_num_reqs;
      if (!grant_any && req_val[idx]) begin
        grant_any = 1'b1;
        grant_id  = id_t'(idx);
      end
    end
  end

  // A full FIFO can still accept a tag when the head pops in the same cycle.
  assign can_issue = !full || (full && resp_fire);

  always_comb begin
    memreq_msg = '0;
    req_rdy    = '0;
    memreq_val = reset_n && grant_any && can_issue;
    for (int k = 0; k < p_num_reqs; k++) begin
      if (int'(grant_id) == k) begin
        memreq_msg = req_msg[k*c_memreq_msg_sz +: c_memreq_msg_sz];
        req_rdy[k] = reset_n && grant_any && memreq_rdy && can_issue;
      end
    end
  end

  // Responses go only to the requester whose tag sits at the FIFO head.
  always_comb begin
    resp_val    = '0;
    memresp_rdy = 1'b0;
    for (int k = 0; k < p_num_reqs; k++) begin
      if (reset_n && !empty && int'(head_id) == k) begin
        resp_val[k] = memresp_val;
        memresp_rdy = resp_rdy[k];
      end
    end
  end

  assign resp_msg   = {p_num_reqs{memresp_msg}};
  assign issue_fire = memreq_val && memreq_rdy;
  assign resp_fire  = memresp_val && memresp_rdy;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (issue_fire) tail <= ptr_inc(tail);
      if (resp_fire)  head <= ptr_inc(head);
      case ({issue_fire, resp_fire})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: tag storage has no reset; occupancy and pointers alone decide validity.
  always_ff @(posedge clk) begin
    if (issue_fire) tags[tail] <= grant_id;
  end

`ifdef VC_MEM_PORT_ARBITER_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        prio <= '0;
    else if (issue_fire) prio <= (grant_id == id_t'(p_num_reqs - 1)) ? '0 : grant_id + id_t'(1);
  end
`endif

endmodule

// File: tb/tb_vc_mem_port_arbiter.sv
// Directed bench for vc_mem_port_arbiter (2 requesters, 4-entry tag FIFO); expected
// grant order follows VC_MEM_PORT_ARBITER_RR_EN when defined.

module tb_vc_mem_port_arbiter;

  localparam int N      = 2;
  localparam int REQ_W  = 43;
  localparam int RESP_W = 35;

`ifdef VC_MEM_PORT_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset_n;
  logic [N*REQ_W-1:0]  req_msg;
  logic [N-1:0]        req_val;
  logic [N-1:0]        req_rdy;
  logic [REQ_W-1:0]    memreq_msg;
  logic                memreq_val;
  logic                memreq_rdy;
  logic [RESP_W-1:0]   memresp_msg;
  logic                memresp_val;
  logic                memresp_rdy;
  logic [N*RESP_W-1:0] resp_msg;
  logic [N-1:0]        resp_val;
  logic [N-1:0]        resp_rdy;

  logic [REQ_W-1:0]    msg0;
  logic [REQ_W-1:0]    msg1;
  int tests  = 0;
  int failed = 0;
  int g;
  int g_prev;
  int pulses;

  always #5 clk = ~clk;

  vc_mem_port_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_msg     (req_msg),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .memreq_msg  (memreq_msg),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memresp_msg (memresp_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy),
    .resp_msg    (resp_msg),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n     = 1'b0;
    req_val     = 2'b11;
    msg0        = 43'h100;
    msg1        = 43'h200;
    req_msg     = {msg1, msg0};
    memreq_rdy  = 1'b1;
    memresp_msg = 35'h0;
    memresp_val = 1'b1;
    resp_rdy    = 2'b11;
    #1;
    check("rst_memreq_val",  memreq_val,  1'b0);
    check("rst_req_rdy",     req_rdy,     2'b00);
    check("rst_memresp_rdy", memresp_rdy, 1'b0);
    check("rst_resp_val",    resp_val,    2'b00);
    tick();
    tick();
    reset_n = 1'b1;

    // Contention: both requesters valid for 6 cycles, responses drain one behind.
    g_prev = 0;
    for (int k = 0; k < 6; k++) begin
      g           = RR ? (k % 2) : 0;
      req_val     = 2'b11;
      msg0        = 43'h100 + 43'(k);
      msg1        = 43'h200 + 43'(k);
      req_msg     = {msg1, msg0};
      memresp_val = (k > 0);
      memresp_msg = 35'h1000 + 35'(k);
      #1;
      check("cont_req_rdy",    req_rdy,    2'b01 << g);
      check("cont_memreq_msg", memreq_msg, (g == 1) ? msg1 : msg0);
      if (k > 0) begin
        check("cont_resp_val",  resp_val, 2'b01 << g_prev);
        check("cont_resp_msg1", resp_msg[RESP_W +: RESP_W], 35'h1000 + 35'(k));
      end
      g_prev = g;
      tick();
    end
    req_val     = 2'b00;
    memresp_val = 1'b1;
    #1;
    check("cont_drain_resp_val", resp_val, 2'b01 << g_prev);
    tick();

    // Single requester: 4 loads, responses return 2 cycles after issue.
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      req_val     = (c < 4) ? 2'b01 : 2'b00;
      msg0        = 43'h300 + 43'(c);
      req_msg     = {msg1, msg0};
      memresp_val = (c >= 2);
      memresp_msg = 35'h2000 + 35'(c);
      #1;
      if (c < 4) begin
        check("single_memreq_val", memreq_val, 1'b1);
        check("single_memreq_msg", memreq_msg, 43'h300 + 43'(c));
      end
      check("single_resp_val", resp_val, (c >= 2) ? 2'b01 : 2'b00);
      if (c >= 2) check("single_resp_msg0", resp_msg[0 +: RESP_W], 35'h2000 + 35'(c));
      if (resp_val[0] && memresp_rdy) pulses++;
      tick();
    end
    check("single_pulses", pulses, 4);

    // Empty FIFO: a response must be held, not accepted.
    req_val     = 2'b00;
    memresp_val = 1'b1;
    #1;
    check("empty_memresp_rdy", memresp_rdy, 1'b0);
    check("empty_resp_val",    resp_val,    2'b00);
    tick();
    memresp_val = 1'b0;

    // FIFO full: requester 1 issues 4, then stalls until a response frees a slot.
    for (int c = 0; c < 4; c++) begin
      req_val = 2'b10;
      #1;
      check("fill_memreq_val", memreq_val, 1'b1);
      check("fill_req_rdy",    req_rdy,    2'b10);
      tick();
    end
    #1;
    check("full_memreq_val", memreq_val, 1'b0);
    check("full_req_rdy",    req_rdy,    2'b00);
    tick();
    memresp_val = 1'b1;
    #1;
    check("pipe_memreq_val",  memreq_val,  1'b1);
    check("pipe_req_rdy",     req_rdy,     2'b10);
    check("pipe_memresp_rdy", memresp_rdy, 1'b1);
    check("pipe_resp_val",    resp_val,    2'b10);
    tick();
    memresp_val = 1'b0;
    #1;
    check("pipe_still_full", memreq_val, 1'b0);

    // Backpressure on requester 1: head held, FIFO stays full.
    for (int c = 0; c < 3; c++) begin
      req_val     = 2'b01;
      memresp_val = 1'b1;
      resp_rdy    = 2'b01;
      #1;
      check("bp_memresp_rdy", memresp_rdy, 1'b0);
      check("bp_resp_val",    resp_val,    2'b10);
      check("bp_memreq_val",  memreq_val,  1'b0);
      tick();
    end
    req_val  = 2'b00;
    resp_rdy = 2'b11;
    #1;
    check("bp_release_memresp_rdy", memresp_rdy, 1'b1);
    check("bp_release_resp_val",    resp_val,    2'b10);
    tick();
    tick();

    // Mid-flight reset with 2 tags outstanding.
    req_val = 2'b11;
    #1;
    check("pre_rst_req_rdy",  req_rdy,  2'b01);
    check("pre_rst_resp_val", resp_val, 2'b10);
    tick();
    #1;
    check("pre_rst_req_rdy2",  req_rdy,  RR ? 2'b10 : 2'b01);
    check("pre_rst_resp_val2", resp_val, 2'b10);
    reset_n = 1'b0;
    #1;
    check("async_memreq_val",  memreq_val,  1'b0);
    check("async_req_rdy",     req_rdy,     2'b00);
    check("async_memresp_rdy", memresp_rdy, 1'b0);
    check("async_resp_val",    resp_val,    2'b00);
    reset_n = 1'b1;
    #1;
    check("post_rst_memresp_rdy", memresp_rdy, 1'b0);
    check("post_rst_resp_val",    resp_val,    2'b00);
    check("post_rst_memreq_val",  memreq_val,  1'b1);
    check("post_rst_req_rdy",     req_rdy,     2'b01);
    tick();
    req_val = 2'b00;
    #1;
    check("post_rst_route", resp_val, 2'b01);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
